// File: rtl/inv_bank_pkg.sv
// ============================================================================
// Module   : inv_bank_pkg
// Brief    : Shared constants and clog2 helper for the inverter bank filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inv_bank_pkg;

    localparam int C_N_CH     = 6;
    localparam int C_FILT_LEN = 4;
    localparam int C_INIT     = 0;

    // Ceiling log2, never less than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        if (res < 1) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_filt_ch.sv
// ============================================================================
// Module   : inv_filt_ch
// Brief    : One debounced inverter/buffer channel. Optional two-flop input
//            synchronizer enabled by macro INV_BANK_SYNC_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inv_filt_ch
    import inv_bank_pkg::*;
#(
    parameter int   FILT_LEN = C_FILT_LEN,
    parameter logic INIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic mode,
    output logic y,
    output logic chg
);

    localparam int            CW     = clog2(FILT_LEN);
    localparam logic [CW-1:0] C_LAST = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic          w_s;
    logic          r_f;
    logic [CW-1:0] r_cnt;
    logic          r_chg;

`ifdef INV_BANK_SYNC_EN
    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= INIT;
            r_s2 <= INIT;
        end else begin
            r_s1 <= a;
            r_s2 <= r_s1;
        end
    end

    assign w_s = r_s2;
`else
    assign w_s = a;
`endif

    // The counter saturates at C_LAST, where the new level is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f   <= INIT;
            r_cnt <= '0;
            r_chg <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            if (w_s == r_f) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_f   <= w_s;
                r_cnt <= '0;
                r_chg <= 1'b1;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end

    assign y   = r_f ^ mode;
    assign chg = r_chg;

endmodule

`default_nettype wire

// File: rtl/inv_bank_filt.sv
// ============================================================================
// Module   : inv_bank_filt
// Brief    : Bank of N_CH independent filtered inverter/buffer channels.
//            Define INV_BANK_SYNC_EN to add a two-flop input synchronizer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inv_bank_filt
    import inv_bank_pkg::*;
#(
    parameter int              N_CH     = C_N_CH,
    parameter int              FILT_LEN = C_FILT_LEN,
    parameter logic [N_CH-1:0] INIT     = N_CH'(C_INIT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] a,
    input  logic [N_CH-1:0] mode,
    output logic [N_CH-1:0] y,
    output logic [N_CH-1:0] chg
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
            inv_filt_ch #(
                .FILT_LEN (FILT_LEN),
                .INIT     (INIT[gi])
            ) u_ch (
                .clk  (clk),
                .rst  (rst),
                .a    (a[gi]),
                .mode (mode[gi]),
                .y    (y[gi]),
                .chg  (chg[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_inv_bank_filt.sv
// ============================================================================
// Module   : tb_inv_bank_filt
// Brief    : Directed self-checking bench for inv_bank_filt (defaults).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inv_bank_filt;

`ifdef INV_BANK_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic       clk;
    logic       rst;
    logic [5:0] a;
    logic [5:0] mode;
    logic [5:0] y;
    logic [5:0] chg;

    int n_total;
    int n_bad;

    inv_bank_filt u_dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .mode (mode),
        .y    (y),
        .chg  (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        a       = 6'h15;
        mode    = 6'h3F;

        // Reset holds Y at INIT^MODE regardless of A
        #2;
        chk("rst_y_async", 32'(y), 32'h3F);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_y", 32'(y), 32'h3F);
            chk("rst_chg", 32'(chg), 32'h00);
        end
        rst = 1'b0;
        a   = 6'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rel_chg", 32'(chg), 32'h00);
            chk("rel_y", 32'(y), 32'h3F);
        end

        // Accepted change on channel 0
        a = 6'h01;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i < LAT) begin
                chk("acc_y_hold", 32'(y), 32'h3F);
                chk("acc_chg_hold", 32'(chg), 32'h00);
            end else begin
                chk("acc_y", 32'(y), 32'h3E);
                chk("acc_chg", 32'(chg), 32'h01);
            end
        end
        tick();
        chk("acc_chg_end", 32'(chg), 32'h00);
        chk("acc_y_end", 32'(y), 32'h3E);

        // Two 3-sample glitches on channel 2 must both be rejected
        for (int g = 0; g < 2; g++) begin
            a = 6'h05;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("glt_y", 32'(y), 32'h3E);
                chk("glt_chg", 32'(chg), 32'h00);
            end
            a = 6'h01;
            for (int i = 0; i < LAT + 2; i++) begin
                tick();
                chk("glt_y_after", 32'(y), 32'h3E);
                chk("glt_chg_after", 32'(chg), 32'h00);
            end
        end

        // MODE change is combinational and never pulses CHG
        mode = 6'h1F;
        #1;
        chk("mode_y", 32'(y), 32'h1E);
        tick();
        chk("mode_chg", 32'(chg), 32'h00);
        chk("mode_y_edge", 32'(y), 32'h1E);
        mode = 6'h3F;
        #1;
        chk("mode_y_back", 32'(y), 32'h3E);

        // Reset mid-count discards the pending count on channel 1
        a = 6'h03;
        tick();
        tick();
        chk("mid_y_pre", 32'(y), 32'h3E);
        rst = 1'b1;
        #2;
        chk("mid_y_rst", 32'(y), 32'h3F);
        chk("mid_chg_rst", 32'(chg), 32'h00);
        rst = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i < LAT) begin
                chk("mid_y_hold", 32'(y), 32'h3F);
                chk("mid_chg_hold", 32'(chg), 32'h00);
            end else begin
                chk("mid_y", 32'(y), 32'h3C);
                chk("mid_chg", 32'(chg), 32'h03);
            end
        end

        // Simultaneous change on all channels
        rst = 1'b1;
        a   = 6'h00;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("sim_y_pre", 32'(y), 32'h3F);
        a = 6'h3F;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i < LAT) begin
                chk("sim_y_hold", 32'(y), 32'h3F);
                chk("sim_chg_hold", 32'(chg), 32'h00);
            end else begin
                chk("sim_y", 32'(y), 32'h00);
                chk("sim_chg", 32'(chg), 32'h3F);
            end
        end
        tick();
        chk("sim_chg_end", 32'(chg), 32'h00);
        chk("sim_y_end", 32'(y), 32'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inv_bank_filt.md
INV_BANK_FILT -- requirements
Module: inv_bank_filt

Interface
REQ-001 The module SHALL have parameter N_CH, default 6, number of independent inverter channels (1..32).
REQ-002 The module SHALL have parameter FILT_LEN, default 4, consecutive stable samples needed to accept a new input level (1..256).
REQ-003 The module SHALL have parameter INIT, default 0, an N_CH-bit reset level of the filtered input state.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-high.
REQ-006 A  input  N_CH  raw channel inputs, asynchronous to CLK.
REQ-007 MODE  input  N_CH  per-channel polarity; 1 = invert (74HC04 behaviour), 0 = buffer.
REQ-008 Y  output  N_CH  channel outputs.
REQ-009 CHG  output  N_CH  one-cycle pulse per channel when its filtered state changes.

Function
REQ-010 Each channel SHALL hold a filtered state F and a stability counter CNT of width clog2(FILT_LEN), minimum 1 bit.
REQ-011 Each channel SHALL compare its sampled input S with F on every rising edge.
REQ-012 When S equals F, the channel SHALL clear CNT to 0.
REQ-013 When S differs from F and CNT is less than FILT_LEN-1, the channel SHALL increment CNT.
REQ-014 When S differs from F and CNT equals FILT_LEN-1, the channel SHALL set F to S, clear CNT, and assert CHG for the next cycle only.
REQ-015 A level held on A for fewer than FILT_LEN consecutive samples SHALL NOT change F or pulse CHG, and CNT SHALL restart from 0 when S returns to F.
REQ-016 With FILT_LEN = 1, F SHALL follow S on every edge with no filtering.
REQ-017 Y SHALL equal F XOR MODE combinationally, so a MODE change alters Y in the same cycle and does not pulse CHG.
REQ-018 Channels SHALL be fully independent, and simultaneous changes on any set of channels SHALL update on the same edge.
REQ-019 Latency without the synchronizer SHALL be: F updates on the FILT_LEN-th rising edge after A changes; CNT SHALL never wrap.

Reset
REQ-020 While RST is high, the module SHALL set F to INIT, CNT to 0, CHG to 0, and every synchronizer stage to INIT, so Y = INIT XOR MODE.
REQ-021 Reset asserted mid-count SHALL discard the pending count, and a level still present after release SHALL need a full FILT_LEN stable samples.
REQ-022 Reset release SHALL never produce a CHG pulse by itself.

Configuration
REQ-023 When macro INV_BANK_SYNC_EN is defined, A SHALL pass through a two-flop synchronizer per channel before becoming S, adding exactly 2 cycles to the latency.
REQ-024 When INV_BANK_SYNC_EN is not defined, S SHALL be A sampled directly by the filter.

Structure
REQ-025 Package inv_bank_pkg SHALL hold the clog2 function and the default constants for N_CH, FILT_LEN and INIT.
REQ-026 Sub-module inv_filt_ch SHALL implement one channel (optional synchronizer, CNT, F, CHG), and the top SHALL instantiate it N_CH times with a generate loop.
REQ-027 The RTL SHALL total 120-400 lines.

Verification
Defaults apply (N_CH=6, FILT_LEN=4, INIT=0, MODE=6'h3F, synchronizer off) unless a scenario states otherwise.
REQ-028 Reset check: assert RST with A=6'h15 -> Y=6'h3F and CHG=0 for the whole reset period.
REQ-029 Accepted change: A[0] 0->1 held -> Y[0] drops on the 4th edge, CHG=6'h01 for exactly one cycle; with INV_BANK_SYNC_EN defined -> 6th edge.
REQ-030 Glitch rejection: A[2]=1 for 3 cycles then 0 -> Y stays 6'h3F and CHG stays 0.
REQ-031 Mode change: MODE[5] 1->0 with A[5]=0 -> Y[5] goes 1->0 combinationally and CHG[5] stays 0.
REQ-032 Reset mid-count: A[1]=1 for 2 edges, pulse RST, keep A[1]=1 -> Y[1] falls on the 4th edge after release.
REQ-033 Simultaneous change: A goes 6'h00->6'h3F -> Y=6'h00 on the 4th edge and CHG=6'h3F for one cycle.
